// File: rtl/text_glyph_renderer_pkg.sv
// Shared constants, prefetch state encoding and address-width helper for the
// character-cell text renderer.
package text_pkg;
  localparam int DEF_GLYPH_W      = 8;
  localparam int DEF_GLYPH_H      = 10;
  localparam int DEF_COLS         = 80;
  localparam int DEF_ROWS         = 30;
  localparam int DEF_BLINK_FRAMES = 30;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_CHAR_RD,
    PF_FONT_RD,
    PF_LOADED
  } pf_state_e;

  function automatic int font_addr_w(input int glyph_h);
    return 8 + $clog2(glyph_h);
  endfunction
endpackage

// File: rtl/text_glyph_renderer_shifter.sv
// Glyph-row shift register with its pixel counter; asks for a reload whenever
// an advance lands on pixel 0 of a cell.
module glyph_shifter #(
  parameter int GLYPH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               adv,
  input  logic [GLYPH_W-1:0] load_bits,
  output logic               bit_out,
  output logic               reload_req
);
  localparam int PW = $clog2(GLYPH_W);

  logic [GLYPH_W-1:0] shreg, cur;
  logic [PW-1:0]      pix;

  assign reload_req = adv && (pix == '0);
  // On a reload the freshly loaded row is shown in the same advance.
  assign cur        = reload_req ? load_bits : shreg;
  assign bit_out    = cur[GLYPH_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      pix   <= '0;
    end else if (clear) begin
      shreg <= '0;
      pix   <= '0;
    end else if (adv) begin
      shreg <= {cur[GLYPH_W-2:0], 1'b0};
      pix   <= (pix == PW'(GLYPH_W-1)) ? '0 : pix + PW'(1);
    end
  end
endmodule

// File: rtl/text_glyph_renderer.sv
// Character-cell text renderer: row/column counters, text/font prefetch FSM,
// cursor compare and blink, feeding a per-cell glyph shifter.
module text_glyph_renderer
  import text_pkg::*;
#(
  parameter int GLYPH_W      = DEF_GLYPH_W,
  parameter int GLYPH_H      = DEF_GLYPH_H,
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_start,
  input  logic                             line_start,
  input  logic                             pixel_en,
  output logic [$clog2(COLS*ROWS)-1:0]     char_addr,
  input  logic [7:0]                       char_data,
  output logic [font_addr_w(GLYPH_H)-1:0]  font_addr,
  input  logic [GLYPH_W-1:0]               font_data,
  input  logic                             cursor_en,
  input  logic [$clog2(COLS)-1:0]          cursor_col,
  input  logic [$clog2(ROWS)-1:0]          cursor_row,
  output logic                             pixel,
  output logic                             pixel_valid
);
  localparam int CAW = $clog2(COLS*ROWS);
  localparam int FAW = font_addr_w(GLYPH_H);
  localparam int GRW = $clog2(GLYPH_H);
  localparam int CW  = $clog2(COLS+1);
  localparam int RW  = $clog2(ROWS+1);
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  pf_state_e          state;
  logic [GRW-1:0]     glyph_row, glyph_row_n;
  logic [RW-1:0]      text_row, text_row_n, row_sel;
  logic [CW-1:0]      col, col_fetch, eff_col, next_fetch, col_sel;
  logic               started, fresh;
  logic [GLYPH_W-1:0] next_glyph, glyph_src;
  logic               hit_next, cur_hit, hit_now;
  logic [BW-1:0]      blink_cnt;
  logic               blink_on;
  logic [FAW-1:0]     font_addr_q;
  logic [CAW-1:0]     launch_addr;
  logic               active, adv, reload_req, bit_out, in_area_now, launch_next;

  always_comb begin
    glyph_row_n = glyph_row;
    text_row_n  = text_row;
    if (frame_start) begin
      glyph_row_n = '0;
      text_row_n  = '0;
    end else if (line_start) begin
      if (glyph_row == GRW'(GLYPH_H-1)) begin
        glyph_row_n = '0;
        if (text_row != RW'(ROWS)) text_row_n = text_row + RW'(1);
      end else begin
        glyph_row_n = glyph_row + GRW'(1);
      end
    end
  end

  assign active     = (col < CW'(COLS)) && (text_row < RW'(ROWS));
  assign adv        = pixel_en && active && !line_start;
  // The first reload of a line shows cell 0; later reloads step to the next cell.
  assign eff_col    = (reload_req && started) ? col + CW'(1) : col;
  assign next_fetch = eff_col + CW'(1);
  assign launch_next = eff_col < CW'(COLS-1);
  assign in_area_now = (eff_col < CW'(COLS)) && (text_row < RW'(ROWS));
  assign hit_now    = reload_req ? hit_next : cur_hit;
  assign glyph_src  = (state == PF_LOADED && fresh) ? font_data : next_glyph;

  assign row_sel     = line_start ? text_row_n : text_row;
  assign col_sel     = line_start ? '0 : next_fetch;
  assign launch_addr = CAW'(32'(row_sel) * 32'(COLS) + 32'(col_sel));

  // Font ROM address follows char_data combinationally so font_data lands at T+3.
  assign font_addr = (state == PF_FONT_RD) ? {char_data, glyph_row} : font_addr_q;

  glyph_shifter #(.GLYPH_W(GLYPH_W)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (line_start),
    .adv        (adv),
    .load_bits  (glyph_src),
    .bit_out    (bit_out),
    .reload_req (reload_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PF_IDLE;
      glyph_row   <= '0;
      text_row    <= '0;
      col         <= '0;
      col_fetch   <= '0;
      started     <= 1'b0;
      fresh       <= 1'b0;
      next_glyph  <= '0;
      hit_next    <= 1'b0;
      cur_hit     <= 1'b0;
      char_addr   <= '0;
      font_addr_q <= '0;
    end else begin
      glyph_row <= glyph_row_n;
      text_row  <= text_row_n;
      if (line_start) begin
        col     <= '0;
        started <= 1'b0;
        fresh   <= 1'b0;
        if (text_row_n < RW'(ROWS)) begin
          state     <= PF_CHAR_RD;
          col_fetch <= '0;
          char_addr <= launch_addr;
        end else begin
          state <= PF_IDLE;
        end
      end else begin
        case (state)
          PF_CHAR_RD: state <= PF_FONT_RD;
          PF_FONT_RD: begin
            font_addr_q <= font_addr;
            hit_next    <= (text_row == RW'(cursor_row)) && (col_fetch == CW'(cursor_col));
            fresh       <= 1'b1;
            state       <= PF_LOADED;
          end
          PF_LOADED: if (fresh) begin
            next_glyph <= font_data;
            fresh      <= 1'b0;
          end
          default: ;
        endcase
        if (reload_req) begin
          col     <= eff_col;
          started <= 1'b1;
          cur_hit <= hit_next;
          fresh   <= 1'b0;
          if (launch_next) begin
            state     <= PF_CHAR_RD;
            col_fetch <= next_fetch;
            char_addr <= launch_addr;
          end else begin
            state <= PF_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES-1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
    end else if (pixel_en && !line_start) begin
      pixel_valid <= in_area_now;
      pixel       <= in_area_now && (bit_out ^ (hit_now && cursor_en && blink_on));
    end
  end
endmodule

// File: tb/tb_text_glyph_renderer.sv
// Directed bench for text_glyph_renderer with a synchronous text buffer and
// font ROM modelled alongside the DUT.
module tb_text_glyph_renderer;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        frame_start = 1'b0, line_start = 1'b0, pixel_en = 1'b0, cursor_en = 1'b0;
  logic [11:0] char_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic [6:0]  cursor_col = 7'd0;
  logic [4:0]  cursor_row = 5'd0;
  logic        pixel, pixel_valid;
  int          n_vec = 0, n_err = 0;
  logic [7:0]  tbuf [0:COLS*ROWS-1];

  text_glyph_renderer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
    .pixel_en(pixel_en), .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .pixel(pixel),
    .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font_fn(input logic [7:0] code, input logic [3:0] row);
    if (code == 8'h41 && row == 4'd1) return 8'h78;
    return code ^ {row, row};
  endfunction

  always @(posedge clk) begin
    char_data <= tbuf[char_addr];
    font_data <= font_fn(font_addr[11:4], font_addr[3:0]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 0; line_start = 0; pixel_en = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Pulse the strobes and wait until T+3, when pixel_en may first be raised.
  task automatic start_line(input logic with_frame);
    frame_start = with_frame; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    tick(); tick();
  endtask

  task automatic grab_bits(input int n, output logic [31:0] bits);
    bits = '0;
    pixel_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      bits = {bits[30:0], pixel};
    end
    pixel_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_vec++; if (pixel !== 1'b0) begin n_err++; $display("FAIL reset_pixel: got %b want 0", pixel); end
    n_vec++; if (pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pixel_valid); end
    n_vec++; if (char_addr !== 12'd0) begin n_err++; $display("FAIL reset_char_addr: got %h want 000", char_addr); end
    n_vec++; if (font_addr !== 12'd0) begin n_err++; $display("FAIL reset_font_addr: got %h want 000", font_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_cell();
    logic [7:0] exp_bits;
    exp_bits = 8'b0111_1000;
    start_line(1'b1);
    tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_vec++; if (char_addr !== 12'd0) begin n_err++; $display("FAIL single_char_addr: got %h want 000", char_addr); end
    tick();
    n_vec++; if (font_addr !== 12'h411) begin n_err++; $display("FAIL single_font_addr: got %h want 411", font_addr); end
    tick();
    pixel_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (pixel !== exp_bits[7-i] || pixel_valid !== 1'b1) begin
        n_err++;
        $display("FAIL single_pixel[%0d]: got %b/%b want %b/1", i, pixel, pixel_valid, exp_bits[7-i]);
      end
    end
    pixel_en = 1'b0;
  endtask

  // Glyph row 2 (line after the single-cell line), pixel_en high throughout.
  task automatic test_back_to_back();
    logic [7:0] g;
    logic       e;
    start_line(1'b0);
    pixel_en = 1'b1;
    for (int i = 0; i < 650; i++) begin
      tick();
      if (i < 640) begin
        g = font_fn(tbuf[i/8], 4'd2);
        e = g[7 - (i % 8)];
        n_vec++;
        if (pixel !== e || pixel_valid !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_pixel[%0d]: got %b/%b want %b/1", i, pixel, pixel_valid, e);
        end
      end else begin
        n_vec++;
        if (pixel_valid !== 1'b0 || pixel !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_tail[%0d]: got %b/%b want 0/0", i, pixel, pixel_valid);
        end
      end
    end
    pixel_en = 1'b0;
    n_vec++; if (char_addr !== 12'd79) begin n_err++; $display("FAIL b2b_last_fetch: got %0d want 79", char_addr); end
  endtask

  // Glyph row 3 aborted at cell 5 with cell 6 in flight, restart on row 4.
  task automatic test_abort();
    logic [31:0] bits;
    start_line(1'b0);
    pixel_en = 1'b1;
    for (int i = 0; i < 41; i++) tick();
    pixel_en = 1'b0;
    n_vec++; if (char_addr !== 12'd6) begin n_err++; $display("FAIL abort_inflight: got %0d want 6", char_addr); end
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_vec++; if (char_addr !== 12'd0) begin n_err++; $display("FAIL abort_refetch: got %0d want 0", char_addr); end
    tick();
    n_vec++; if (font_addr !== 12'h414) begin n_err++; $display("FAIL abort_font_addr: got %h want 414", font_addr); end
    tick();
    grab_bits(16, bits);
    n_vec++; if (bits[15:8] !== 8'h05) begin n_err++; $display("FAIL abort_cell0: got %h want 05", bits[15:8]); end
    n_vec++; if (bits[7:0] !== 8'h06) begin n_err++; $display("FAIL abort_cell1: got %h want 06", bits[7:0]); end
  endtask

  task automatic test_row_wrap();
    start_line(1'b1);
    for (int k = 1; k <= 300; k++) begin
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      if (k == 10) begin
        n_vec++; if (char_addr !== 12'd80) begin n_err++; $display("FAIL wrap_row1_addr: got %0d want 80", char_addr); end
      end
      if (k == 300) begin
        n_vec++; if (char_addr !== 12'd2320) begin n_err++; $display("FAIL wrap_offscreen_addr: got %0d want 2320", char_addr); end
      end
      tick(); tick(); tick();
    end
    pixel_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (pixel_valid !== 1'b0 || pixel !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_offscreen_pixel[%0d]: got %b/%b want 0/0", i, pixel, pixel_valid);
      end
    end
    pixel_en = 1'b0;
    n_vec++; if (char_addr !== 12'd2320) begin n_err++; $display("FAIL wrap_char_hold: got %0d want 2320", char_addr); end
    n_vec++; if (font_addr !== 12'h479) begin n_err++; $display("FAIL wrap_font_hold: got %h want 479", font_addr); end
  endtask

  // Cursor on cell 2 of row 0; frames 1..29 inverted, 30..59 normal.
  task automatic test_cursor_blink();
    logic [31:0] bits;
    logic [7:0]  exp2;
    do_reset();
    cursor_col = 7'd2; cursor_row = 5'd0; cursor_en = 1'b1;
    for (int f = 1; f <= 59; f++) begin
      start_line(1'b1);
      grab_bits(32, bits);
      exp2 = (f < 30) ? 8'hBC : 8'h43;
      n_vec++;
      if (bits[15:8] !== exp2) begin n_err++; $display("FAIL blink_cell2_f%0d: got %h want %h", f, bits[15:8], exp2); end
      if (f == 1 || f == 30) begin
        n_vec++;
        if (bits[31:16] !== 16'h4142 || bits[7:0] !== 8'h44) begin
          n_err++;
          $display("FAIL blink_neighbours_f%0d: got %h want 41424344 outside cell2", f, bits);
        end
      end
    end
  endtask

  // Runs with the blink phase off; reset must restore it to on.
  task automatic test_reset_midline();
    logic [31:0] bits;
    start_line(1'b0);
    pixel_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_vec++; if (pixel_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", pixel_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (pixel !== 1'b0 || pixel_valid !== 1'b0 || char_addr !== 12'd0 || font_addr !== 12'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got pix=%b vld=%b ca=%h fa=%h want all 0", pixel, pixel_valid, char_addr, font_addr);
    end
    pixel_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_line(1'b1);
    grab_bits(32, bits);
    n_vec++; if (bits[15:8] !== 8'hBC) begin n_err++; $display("FAIL rstmid_blink_on: got %h want bc", bits[15:8]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < COLS*ROWS; a++) tbuf[a] = 8'(8'h41 + (a % 26));
    #2;
    test_reset();
    test_single_cell();
    test_back_to_back();
    test_abort();
    test_row_wrap();
    test_cursor_blink();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
